// File: rtl/chnl_pkg.sv
// Shared definitions for the channel arbiter: FSM state encoding and the
// grant-index width helper.
package chnl_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } state_e;

    // Index width, never narrower than one bit.
    function automatic int unsigned calc_idw(int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// searching upward modulo N.
module rr_pick import chnl_pkg::*; #(
    parameter int unsigned N = 4,
    localparam int unsigned IDW = calc_idw(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           any,
    output logic [IDW-1:0] idx
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic           hit;
    int unsigned    off;

    always_comb begin
        // Rotate so that bit 0 of rot is the request at ptr.
        dbl = {req, req} >> ptr;
        rot = dbl[N-1:0];
        hit = 1'b0;
        off = 0;
        for (int unsigned i = 0; i < N; i++) begin
            if (rot[i] && !hit) begin
                hit = 1'b1;
                off = i;
            end
        end
        any = |req;
        idx = IDW'((32'(ptr) + off) % N);
    end

endmodule

// File: rtl/chnl_arbiter.sv
// Round-robin merge of N valid/ready streams onto one output, with grants
// bounded to BURST beats (0 = until the granted stream's valid drops).
module chnl_arbiter import chnl_pkg::*; #(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BURST = 8,
    localparam int unsigned IDW  = calc_idw(N)
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               en_i,
    input  logic [N-1:0]       in_val_i,
    input  logic [N*WIDTH-1:0] in_data_i,
    output logic [N-1:0]       in_rdy_o,
    output logic               out_val_o,
    output logic [WIDTH-1:0]   out_data_o,
    output logic [IDW-1:0]     out_id_o,
    input  logic               out_rdy_i
);

    localparam int unsigned   CW       = (BURST == 0) ? 1 : $clog2(BURST + 1);
    localparam logic [CW-1:0] LastBeat = CW'(BURST - 1);
    localparam logic [IDW-1:0] LastIdx = IDW'(N - 1);

    state_e           state_q, state_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]    beat_q, beat_d;

    logic             pick_any;
    logic [IDW-1:0]   pick_idx;
    logic             sel_val;
    logic             xfer;
    logic [WIDTH-1:0] lane [N];

    for (genvar k = 0; k < N; k++) begin : g_lane
        assign lane[k] = in_data_i[k*WIDTH +: WIDTH];
    end

    rr_pick #(
        .N (N)
    ) u_rr_pick (
        .req (in_val_i),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Output path is combinational off the granted stream; en_i gates it at once.
    always_comb begin
        sel_val    = in_val_i[grant_q];
        xfer       = (state_q == StGrant) && en_i && sel_val && out_rdy_i;
        out_val_o  = 1'b0;
        in_rdy_o   = '0;
        out_data_o = lane[grant_q];
        out_id_o   = grant_q;
        if (state_q == StGrant && en_i) begin
            out_val_o          = sel_val;
            in_rdy_o[grant_q]  = out_rdy_i;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        case (state_q)
            StIdle: begin
                if (en_i && pick_any) begin
                    grant_d = pick_idx;
                    beat_d  = '0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (xfer) begin
                    beat_d = beat_q + 1'b1;
                end
                if (!en_i || !sel_val || (BURST != 0 && xfer && beat_q == LastBeat)) begin
                    state_d = StIdle;
                    ptr_d   = (grant_q == LastIdx) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
        end
    end

endmodule

// File: tb/tb_chnl_arbiter.sv
// Directed bench for chnl_arbiter: four instances (BURST 2/4/8/0) share the
// stimulus; each scenario checks the instance whose burst limit it targets.
module tb_chnl_arbiter;

    localparam logic [31:0] LANE = 32'hC0DE_0000;

    logic         clk;
    logic         rstn;
    logic         en;
    logic [3:0]   val;
    logic [127:0] data;
    logic         rdy;

    logic [3:0]  b2_irdy, b4_irdy, b8_irdy, b0_irdy;
    logic        b2_oval, b4_oval, b8_oval, b0_oval;
    logic [31:0] b2_odata, b4_odata, b8_odata, b0_odata;
    logic [1:0]  b2_oid, b4_oid, b8_oid, b0_oid;

    int n_total = 0;
    int n_bad   = 0;

    chnl_arbiter #(.N(4), .WIDTH(32), .BURST(2)) u_b2 (
        .clk_i(clk), .rstn_i(rstn), .en_i(en), .in_val_i(val), .in_data_i(data),
        .in_rdy_o(b2_irdy), .out_val_o(b2_oval), .out_data_o(b2_odata),
        .out_id_o(b2_oid), .out_rdy_i(rdy)
    );
    chnl_arbiter #(.N(4), .WIDTH(32), .BURST(4)) u_b4 (
        .clk_i(clk), .rstn_i(rstn), .en_i(en), .in_val_i(val), .in_data_i(data),
        .in_rdy_o(b4_irdy), .out_val_o(b4_oval), .out_data_o(b4_odata),
        .out_id_o(b4_oid), .out_rdy_i(rdy)
    );
    chnl_arbiter #(.N(4), .WIDTH(32), .BURST(8)) u_b8 (
        .clk_i(clk), .rstn_i(rstn), .en_i(en), .in_val_i(val), .in_data_i(data),
        .in_rdy_o(b8_irdy), .out_val_o(b8_oval), .out_data_o(b8_odata),
        .out_id_o(b8_oid), .out_rdy_i(rdy)
    );
    chnl_arbiter #(.N(4), .WIDTH(32), .BURST(0)) u_b0 (
        .clk_i(clk), .rstn_i(rstn), .en_i(en), .in_val_i(val), .in_data_i(data),
        .in_rdy_o(b0_irdy), .out_val_o(b0_oval), .out_data_o(b0_odata),
        .out_id_o(b0_oid), .out_rdy_i(rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset across an edge, release mid-cycle; returns in the first IDLE cycle.
    task automatic restart(input logic [3:0] v);
        rstn = 1'b0;
        val  = v;
        en   = 1'b1;
        rdy  = 1'b1;
        tick();
        rstn = 1'b1;
        #1;
    endtask

    int pat [13] = '{0, 0, -1, 1, 1, -1, 2, 2, -1, 3, 3, -1, 0};
    bit rp  [7]  = '{1, 0, 0, 1, 1, 1, 1};
    bit ev  [7]  = '{1, 1, 1, 1, 1, 1, 0};
    int beats;
    int gaps;

    initial begin
        rstn = 1'b0;
        en   = 1'b1;
        val  = 4'hF;
        rdy  = 1'b1;
        data = {LANE + 32'd3, LANE + 32'd2, LANE + 32'd1, LANE + 32'd0};

        // Reset held with every stream requesting.
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            chk("rst_val", 32'(b2_oval), 0);
            chk("rst_rdy", 32'(b2_irdy), 0);
            chk("rst_id", 32'(b2_oid), 0);
            chk("rst_val_b0", 32'(b0_oval), 0);
        end

        // Fairness, BURST=2, all streams valid.
        rstn = 1'b1;
        #1;
        chk("arb_lat", 32'(b2_oval), 0);
        for (int i = 0; i < 13; i++) begin
            tick();
            #1;
            if (pat[i] < 0) begin
                chk("fair_bubble", 32'(b2_oval), 0);
            end else begin
                chk("fair_val", 32'(b2_oval), 1);
                chk("fair_id", 32'(b2_oid), 32'(pat[i]));
                chk("fair_data", b2_odata, LANE + 32'(pat[i]));
                chk("fair_rdy", 32'(b2_irdy), 32'(4'b0001 << pat[i]));
            end
        end
        // Mid-burst reset drops the handshake immediately.
        rstn = 1'b0;
        #1;
        chk("rst_mid_val", 32'(b2_oval), 0);
        chk("rst_mid_rdy", 32'(b2_irdy), 0);

        // Gap, BURST=8: stream 2 sends 3 beats then drops.
        restart(4'b0100);
        chk("gap_idle", 32'(b8_oval), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            chk("gap_val", 32'(b8_oval), 1);
            chk("gap_id", 32'(b8_oid), 2);
        end
        tick();
        val = 4'b0000;
        #1;
        chk("gap_drop", 32'(b8_oval), 0);
        tick();
        val = 4'b1001;
        #1;
        chk("gap_bubble", 32'(b8_oval), 0);
        tick();
        #1;
        chk("gap_next_val", 32'(b8_oval), 1);
        chk("gap_next_id", 32'(b8_oid), 3);

        // Backpressure, BURST=4, stream 1 alone.
        restart(4'b0010);
        chk("bp_idle", 32'(b4_oval), 0);
        beats = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            rdy = rp[i];
            #1;
            chk("bp_val", 32'(b4_oval), 32'(ev[i]));
            chk("bp_rdy", 32'(b4_irdy), (ev[i] && rp[i]) ? 32'h2 : 32'h0);
            if (ev[i]) begin
                chk("bp_data", b4_odata, LANE + 32'd1);
                chk("bp_id", 32'(b4_oid), 1);
            end
            if (b4_oval && rdy) beats++;
        end
        chk("bp_beats", 32'(beats), 4);
        tick();
        #1;
        chk("bp_regrant_val", 32'(b4_oval), 1);
        chk("bp_regrant_id", 32'(b4_oid), 1);

        // Abort, BURST=4: en_i drops after the first beat.
        restart(4'b0110);
        chk("ab_idle", 32'(b4_oval), 0);
        tick();
        #1;
        chk("ab_val", 32'(b4_oval), 1);
        chk("ab_id", 32'(b4_oid), 1);
        tick();
        en = 1'b0;
        #1;
        chk("ab_off_val", 32'(b4_oval), 0);
        chk("ab_off_rdy", 32'(b4_irdy), 0);
        tick();
        en = 1'b1;
        #1;
        chk("ab_bubble", 32'(b4_oval), 0);
        tick();
        #1;
        chk("ab_next_val", 32'(b4_oval), 1);
        chk("ab_next_id", 32'(b4_oid), 2);

        // Unlimited burst, BURST=0: 100 beats from stream 1 under one grant.
        restart(4'b0010);
        chk("unl_idle", 32'(b0_oval), 0);
        beats = 0;
        gaps  = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            #1;
            if (b0_oval && rdy && b0_oid == 2'd1 && b0_irdy == 4'b0010) beats++;
            else gaps++;
        end
        chk("unl_beats", 32'(beats), 100);
        chk("unl_gaps", 32'(gaps), 0);
        tick();
        val = 4'b0000;
        #1;
        chk("unl_end", 32'(b0_oval), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/chnl_arbiter.md
CHNL_ARBITER -- requirements
Module: chnl_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesting FIFO streams; legal range 2..16.
REQ-002 Parameter WIDTH, default 32: data width per stream.
REQ-003 Parameter BURST, default 8: maximum beats per grant; 0 means unlimited, with the grant held until the granted stream's valid drops.
REQ-004 Single clock and reset: the block SHALL use one clock (clk_i); reset is asynchronous and active-low (rstn_i).
REQ-005 Port list (name, direction, width, meaning):
- clk_i, in, 1, clock.
- rstn_i, in, 1, async active-low reset.
- en_i, in, 1, global enable.
- in_val_i, in, N, per-stream valid.
- in_data_i, in, N*WIDTH, stream k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH].
- in_rdy_o, out, N, per-stream ready.
- out_val_o, out, 1, merged valid.
- out_data_o, out, WIDTH, merged data.
- out_id_o, out, IDW = max(1, clog2(N)), index of the granted stream.
- out_rdy_i, in, 1, downstream ready.

Function
REQ-006 A transfer SHALL occur on a port in any cycle where its valid and ready are both high at the rising edge of clk_i.
REQ-007 States SHALL be IDLE and GRANT; after reset the state is IDLE.
REQ-008 In IDLE, out_val_o=0 and in_rdy_o=0.
REQ-009 In IDLE with en_i=1 and any in_val_i bit set, the block SHALL latch as grant the first set index at or after rr_ptr, searching upward modulo N, clear beat_cnt, and enter GRANT on the next edge.
- Arbitration latency: exactly one cycle from valid to first possible beat.
REQ-010 In GRANT, the output path SHALL be combinational:
- out_val_o = in_val_i[grant].
- out_data_o = in_data_i[grant].
- out_id_o = grant.
- in_rdy_o[grant] = out_rdy_i; all other in_rdy_o bits 0.
REQ-011 Each output transfer SHALL increment beat_cnt; the counter width is clog2(BURST+1), and it is unused when BURST=0.
REQ-012 GRANT SHALL exit to IDLE at the next edge on any of the following:
- a transfer with beat_cnt = BURST-1 (BURST>0);
- in_val_i[grant]=0 (stream gap or empty);
- en_i=0.
REQ-013 On every GRANT exit, rr_ptr SHALL become (grant+1) mod N; otherwise rr_ptr holds.
REQ-014 No beat SHALL be lost or duplicated: a beat stalled by out_rdy_i=0 remains presented with out_val_o=1 until accepted, and the grant is not revoked while in_val_i[grant]=1 and the beat limit is not reached.
REQ-015 When en_i=0, out_val_o and all in_rdy_o SHALL be 0 in the same cycle, and the state returns to IDLE at the next edge.
REQ-016 Requests from non-granted streams during GRANT SHALL be ignored until the next IDLE cycle.
REQ-017 A lone requester SHALL be regranted after a one-cycle IDLE bubble; the exiting grant has no fairness priority over other requesters.

Reset
REQ-018 While rstn_i=0, the block SHALL hold the state at IDLE and grant=0, rr_ptr=0 and beat_cnt=0 asynchronously; out_val_o=0, in_rdy_o=0 and out_id_o=0.
REQ-019 Reset asserted mid-burst SHALL drop out_val_o and in_rdy_o immediately, with no partial-beat handshake.
REQ-020 Deassertion of rstn_i SHALL be taken as synchronous to clk_i, and the first arbitration SHALL occur no earlier than the first edge after deassertion.

Structure
REQ-021 The state encodings (IDLE=0, GRANT=1) and the IDW computation function SHALL live in the shared package chnl_pkg.
REQ-022 Round-robin selection SHALL be implemented in sub-module rr_pick, which is purely combinational:
- inputs: req[N], ptr[IDW];
- outputs: any, idx[IDW].
REQ-023 The top-level module SHALL contain the FSM, the grant/pointer/counter registers and the output multiplexer.

Verification
REQ-024 Reset: with rstn_i=0 and all in_val_i=1 -> out_val_o=0, in_rdy_o=0 and out_id_o=0 for every cycle.
REQ-025 Fairness: N=4, BURST=2, all streams continuously valid, out_rdy_i=1 -> out_id_o sequence 0,0,-,1,1,-,2,2,-,3,3,-,0 (- = IDLE bubble).
REQ-026 Gap: stream 2 alone sends 3 beats then drops valid, BURST=8 -> exit after beat 3, rr_ptr=3, next grant to stream 3 when it requests.
REQ-027 Backpressure: out_rdy_i toggles 1,0,0,1 during a burst -> data held stable while stalled, beat_cnt advances only on accepted beats, and exactly BURST beats are delivered.
REQ-028 Abort: en_i=0 after beat 1 of 4, then en_i=1 -> out_val_o=0 that cycle, the burst is not completed, and the next grant goes to (grant+1) mod N if that stream is valid.
REQ-029 Unlimited burst: BURST=0, stream 1 supplies 100 beats -> a single grant of 100 beats with no bubble.
